io_decoder: RTL and testbench
=============================

Name: io_decoder

Overview:
- Sits directly downstream of the I/O bridge master port and turns its single registered bus into per-device chip selects.
- Decodes address bits [19:16] into up to 16 64 KB device slots and forwards the cycle to the selected device.
- Muxes the selected device's ack and data back to the bridge, and holds ack until the strobe drops.
- Unmapped slots and hung devices get a bus-error ack, so the bridge never stalls.

Parameters:
- NDEV, 8: number of populated device slots (1..16); slot indices >= NDEV are unmapped.
- TO_CYCLES, 255: timeout limit in clocks while waiting for a device ack (1..65535).
- SLOT_MASK, 16'h00FF: per-slot enable bitmap; a cleared bit makes that slot unmapped even if its index is < NDEV.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- s_cyc_i  in  1  cycle from bridge
- s_stb_i  in  1  strobe from bridge
- s_we_i  in  1  write enable
- s_sel_i  in  4  byte selects
- s_adr_i  in  32  address; only [19:0] is used
- s_dat_i  in  32  write data
- s_core_i  in  6  requesting core id
- s_ack_o  out  1  ack to bridge
- s_err_o  out  1  bus error, valid while s_ack_o is high
- s_dat_o  out  32  read data
- s_core_o  out  6  core id returned with ack
- d_cs_o  out  NDEV  one-hot device select
- d_we_o  out  1  registered write enable
- d_sel_o  out  4  registered byte selects
- d_adr_o  out  16  registered offset s_adr_i[15:0]
- d_dat_o  out  32  registered write data
- d_ack_i  in  NDEV  per-device ack
- d_dat_i  in  NDEV*32  per-device read data; slot k occupies bits [32k+31:32k]

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset is asynchronous, so an in-flight cycle is abandoned immediately.
- IDLE:
  - Acts when s_cyc_i & s_stb_i & ~s_ack_o.
  - Computes slot = s_adr_i[19:16] and latches we, sel, adr[15:0], dat and core.
  - Mapped slot (slot < NDEV and SLOT_MASK[slot]): d_cs_o[slot] <= 1, timeout counter cleared, go to WAIT.
  - Unmapped slot: go to ERR.
  - Latency from request to chip select is 1 clock.
- WAIT:
  - If d_ack_i[slot]: s_dat_o <= d_dat_i of that slot (forced to 0 on writes), s_core_o <= latched core, s_ack_o <= 1, s_err_o <= 0, d_cs_o <= 0, go to RESP.
  - Else if ~s_cyc_i (abort): d_cs_o <= 0, go to IDLE, no ack is issued.
  - Acks from non-selected slots are ignored.
- ERR: s_ack_o <= 1, s_err_o <= 1, s_dat_o <= 32'hFFFFFFFF, go to RESP.
- RESP:
  - Holds ack, err, dat and core stable while s_stb_i is high.
  - When s_stb_i goes low: clears s_ack_o, s_err_o, s_dat_o and s_core_o, and goes to IDLE.
  - A new request is not accepted in the same clock ack drops; the earliest re-accept is the clock after.
- Ack is a level handshake:
  - It rises only after the device ack.
  - It never rises twice for one strobe.
  - Minimum cost is 2 clocks of bridge-visible latency plus device latency.
- Device ack is sampled while d_cs_o is high. A device that holds ack past its cs deassertion has no effect, because the decoder is in RESP or IDLE.
- Same-clock abort and device ack in WAIT: the ack wins and the block goes to RESP; the bridge drops stb and RESP exits.
- d_we_o, d_sel_o, d_adr_o and d_dat_o remain latched after the cycle; only d_cs_o qualifies them.

Optional Feature:
- Macro IO_DECODER_TIMEOUT_EN.
- Defined:
  - The WAIT counter increments every clock.
  - When it reaches TO_CYCLES with no ack, d_cs_o <= 0 and the block goes to ERR, so the bridge sees s_err_o = 1 and data 32'hFFFFFFFF.
  - The counter is 16 bits and saturates, so it never wraps.
- Undefined: there is no counter and WAIT waits indefinitely for the ack or an abort.

Decomposition:
- Shared package io_pkg:
  - state enum {IDLE, WAIT, ERR, RESP};
  - IO_BASE = 12'hFD0;
  - BUS_ERR_DATA = 32'hFFFFFFFF;
  - slot width constant SLOT_W = 4.
- Sub-module io_slot_mux is natural: a combinational NDEV-way ack/data select indexed by the latched slot.

Test Plan:
- Read slot 2, device acks 3 clocks after cs with 32'hCAFEBABE -> d_cs_o = 8'b00000100 one clock after stb; s_ack_o = 1 with s_dat_o = 32'hCAFEBABE and s_core_o equal to the request's core; ack held until stb drops, then all zero.
- Write adr 32'hFD05_1234, dat 32'h11223344, sel 4'hC -> d_adr_o = 16'h1234, d_dat_o = 32'h11223344, d_sel_o = 4'hC, d_cs_o[5] = 1, d_we_o = 1; ack returns with s_dat_o = 0.
- Access slot 10 with NDEV = 8 -> no chip select; s_ack_o = 1 and s_err_o = 1 with data 32'hFFFFFFFF two clocks after the request.
- Slot 1 never acks, macro defined, TO_CYCLES = 20 -> cs drops after 20 clocks, then an error ack; macro undefined -> no ack, and dropping s_cyc_i returns to IDLE with cs cleared.
- Bridge drops cyc in WAIT in the same clock the device acks -> exactly one ack pulse, which clears when stb is low.
- rst_ni asserted mid-WAIT -> d_cs_o, s_ack_o and s_dat_o are 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/io_pkg.sv
// Shared types and constants for the I/O decoder slice.
package io_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ERR, RESP} state_t;

  localparam logic [11:0] IO_BASE      = 12'hFD0;
  localparam logic [31:0] BUS_ERR_DATA = 32'hFFFFFFFF;
  localparam int          SLOT_W       = 4;

endpackage

// File: rtl/io_decoder_if.sv
// Registered bridge-side bus between the I/O bridge master port and the decoder.
interface io_decoder_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [5:0]  core;
  logic        ack;
  logic        err;
  logic [31:0] rdat;
  logic [5:0]  rcore;

  modport master (output cyc, stb, we, sel, adr, wdat, core,
                  input  ack, err, rdat, rcore);
  modport slave  (input  cyc, stb, we, sel, adr, wdat, core,
                  output ack, err, rdat, rcore);

endinterface

// File: rtl/io_slot_mux.sv
// Selects the ack and read data of the device in the latched slot; unpopulated slots read as idle.
module io_slot_mux
  import io_pkg::*;
#(
  parameter int NDEV = 8
) (
  input  logic [SLOT_W-1:0]  slot,
  input  logic [NDEV-1:0]    d_ack,
  input  logic [NDEV*32-1:0] d_dat,
  output logic               ack,
  output logic [31:0]        dat
);

  always_comb begin
    ack = 1'b0;
    dat = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (slot == SLOT_W'(k)) begin
        ack = d_ack[k];
        dat = d_dat[32*k +: 32];
      end
    end
  end

endmodule

// File: rtl/io_decoder.sv
// Decodes adr[19:16] into per-device chip selects and returns ack/data or a bus error to the bridge.
// Optional device-ack timeout is enabled by defining IO_DECODER_TIMEOUT_EN.
module io_decoder
  import io_pkg::*;
#(
  parameter int          NDEV      = 8,
  parameter int          TO_CYCLES = 255,
  parameter logic [15:0] SLOT_MASK = 16'h00FF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  io_decoder_if.slave        bus,
  output logic [NDEV-1:0]    d_cs_o,
  output logic               d_we_o,
  output logic [3:0]         d_sel_o,
  output logic [15:0]        d_adr_o,
  output logic [31:0]        d_dat_o,
  input  logic [NDEV-1:0]    d_ack_i,
  input  logic [NDEV*32-1:0] d_dat_i
);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [NDEV-1:0]   cs_q, cs_d;
  logic              ack_q, ack_d, err_q, err_d;
  logic [31:0]       rdat_q, rdat_d;
  logic [5:0]        rcore_q, rcore_d, core_q, core_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [15:0]       adr_q, adr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic              mux_ack;
  logic [31:0]       mux_dat;
  logic [SLOT_W-1:0] req_slot;
  logic              req_mapped;
  logic              unused_base_hit;

`ifdef IO_DECODER_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`else
  localparam int unused_to_cycles = TO_CYCLES;
`endif

  assign req_slot        = bus.adr[19:16];
  assign req_mapped      = (int'(req_slot) < NDEV) && SLOT_MASK[req_slot];
  assign unused_base_hit = (bus.adr[31:20] == IO_BASE);

  io_slot_mux #(.NDEV(NDEV)) u_mux (
    .slot  (slot_q),
    .d_ack (d_ack_i),
    .d_dat (d_dat_i),
    .ack   (mux_ack),
    .dat   (mux_dat)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cs_d    = cs_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    rcore_d = rcore_q;
    core_d  = core_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
`ifdef IO_DECODER_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cyc && bus.stb && !ack_q) begin
          slot_d = req_slot;
          we_d   = bus.we;
          sel_d  = bus.sel;
          adr_d  = bus.adr[15:0];
          wdat_d = bus.wdat;
          core_d = bus.core;
          if (req_mapped) begin
            for (int k = 0; k < NDEV; k++) cs_d[k] = (req_slot == SLOT_W'(k));
`ifdef IO_DECODER_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = WAIT;
          end else begin
            state_d = ERR;
          end
        end
      end
      // A device ack beats a same-clock abort so the bridge still gets its one ack.
      WAIT: begin
        if (mux_ack) begin
          rdat_d  = we_q ? '0 : mux_dat;
          rcore_d = core_q;
          ack_d   = 1'b1;
          err_d   = 1'b0;
          cs_d    = '0;
          state_d = RESP;
        end else if (!bus.cyc) begin
          cs_d    = '0;
          state_d = IDLE;
        end else begin
`ifdef IO_DECODER_TIMEOUT_EN
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          if (cnt_q == 16'(TO_CYCLES - 1)) begin
            cs_d    = '0;
            state_d = ERR;
          end
`endif
        end
      end
      ERR: begin
        ack_d   = 1'b1;
        err_d   = 1'b1;
        rdat_d  = BUS_ERR_DATA;
        rcore_d = core_q;
        state_d = RESP;
      end
      RESP: begin
        if (!bus.stb) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          rdat_d  = '0;
          rcore_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cs_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      rcore_q <= '0;
      core_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
`ifdef IO_DECODER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cs_q    <= cs_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      rcore_q <= rcore_d;
      core_q  <= core_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
`ifdef IO_DECODER_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdat  = rdat_q;
  assign bus.rcore = rcore_q;
  assign d_cs_o    = cs_q;
  assign d_we_o    = we_q;
  assign d_sel_o   = sel_q;
  assign d_adr_o   = adr_q;
  assign d_dat_o   = wdat_q;

endmodule

// File: tb/tb_io_decoder.sv
// Randomized and directed bench for io_decoder against a transaction-level reference model.
module tb_io_decoder;
  import io_pkg::*;

  localparam int          NDEV = 8;
  localparam int          TO   = 20;
  localparam logic [15:0] MASK = 16'h00F7;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NDEV-1:0]     cs, d_ack;
  logic                d_we;
  logic [3:0]          d_sel;
  logic [15:0]         d_adr;
  logic [31:0]         d_dat_o;
  logic [NDEV*32-1:0]  d_dat;
  int                  checks = 0;
  int                  errors = 0;

  io_decoder_if bus();

  io_decoder #(.NDEV(NDEV), .TO_CYCLES(TO), .SLOT_MASK(MASK)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .d_cs_o  (cs),
    .d_we_o  (d_we),
    .d_sel_o (d_sel),
    .d_adr_o (d_adr),
    .d_dat_o (d_dat_o),
    .d_ack_i (d_ack),
    .d_dat_i (d_dat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which slots answer, and what a completed cycle returns.
  function automatic bit isMapped(input int slot);
    return (slot < NDEV) && MASK[slot];
  endfunction

  function automatic logic [31:0] expData(input int slot, input bit we, input logic [31:0] devData);
    if (!isMapped(slot)) return 32'hFFFFFFFF;
    return we ? 32'h0 : devData;
  endfunction

  function automatic logic [NDEV-1:0] oneHot(input int slot);
    logic [NDEV-1:0] v;
    v = '0;
    if (slot < NDEV) v[slot] = 1'b1;
    return v;
  endfunction

  task automatic startRequest(input int slot, input bit we, input logic [15:0] off,
                              input logic [31:0] wdat, input logic [3:0] sel, input logic [5:0] core);
    logic [3:0] s4;
    s4 = slot[3:0];
    bus.cyc  = 1'b1;
    bus.stb  = 1'b1;
    bus.we   = we;
    bus.sel  = sel;
    bus.adr  = {IO_BASE, s4, off};
    bus.wdat = wdat;
    bus.core = core;
  endtask

  task automatic applyStimulus(input int slot, input bit we, input int lat, input logic [31:0] devData,
                               input logic [15:0] off, input logic [31:0] wdat,
                               input logic [3:0] sel, input logic [5:0] core);
    logic [31:0] exp;
    exp = expData(slot, we, devData);
    startRequest(slot, we, off, wdat, sel, core);
    tick();
    if (isMapped(slot)) begin
      checkOutput("cs", cs, oneHot(slot));
      checkOutput("dev_fields", {d_we, d_sel, d_adr, d_dat_o}, {we, sel, off, wdat});
      for (int i = 0; i < lat; i++) begin
        d_ack = NDEV'($urandom) & ~oneHot(slot);
        d_dat = {NDEV{$urandom}};
        tick();
        checkOutput("ack_early", bus.ack, 1'b0);
      end
      d_ack = oneHot(slot) | (NDEV'($urandom) & ~oneHot(slot));
      d_dat = {NDEV{$urandom}};
      d_dat[32*slot +: 32] = devData;
      tick();
      d_ack = '0;
      checkOutput("ack", {bus.ack, bus.err}, 2'b10);
      checkOutput("cs_drop", cs, '0);
    end else begin
      checkOutput("cs_unmapped", cs, '0);
      tick();
      checkOutput("err_ack", {bus.ack, bus.err}, 2'b11);
    end
    checkOutput("rdat", bus.rdat, exp);
    if (isMapped(slot)) checkOutput("rcore", bus.rcore, core);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("ack_hold", {bus.ack, bus.rdat}, {1'b1, exp});
    end
    bus.stb = 1'b0;
    bus.cyc = 1'b0;
    tick();
    checkOutput("resp_clear", {bus.ack, bus.err, bus.rdat, bus.rcore}, '0);
  endtask

  task automatic hungDevice(input int slot);
    int  n;
    bit  sawAck;
    startRequest(slot, 1'b0, 16'h0040, 32'h0, 4'hF, 6'h11);
    tick();
    checkOutput("hung_cs", cs, oneHot(slot));
`ifdef IO_DECODER_TIMEOUT_EN
    n = 0;
    while (cs != '0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("to_len", n, TO);
    tick();
    checkOutput("to_err", {bus.ack, bus.err, bus.rdat}, {2'b11, 32'hFFFFFFFF});
    bus.stb = 1'b0;
    bus.cyc = 1'b0;
    tick();
    checkOutput("to_clear", bus.ack, 1'b0);
`else
    sawAck = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ack) sawAck = 1'b1;
    end
    checkOutput("hung_noack", sawAck, 1'b0);
    checkOutput("hung_cs_held", cs, oneHot(slot));
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    tick();
    checkOutput("abort_cs", cs, '0);
    tick();
    checkOutput("abort_noack", bus.ack, 1'b0);
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pulses;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.sel = '0;
    bus.adr = '0; bus.wdat = '0; bus.core = '0;
    d_ack = '0;
    d_dat = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset", {cs, bus.ack, bus.err, bus.rdat, bus.rcore, d_we, d_sel, d_adr}, '0);
    rst_n = 1'b1;
    tick();

    $display("[TB] directed read/write/unmapped");
    applyStimulus(2, 1'b0, 3, 32'hCAFEBABE, 16'h0010, 32'h0, 4'hF, 6'h2A);
    applyStimulus(5, 1'b1, 1, 32'hDEADBEEF, 16'h1234, 32'h11223344, 4'hC, 6'h05);
    applyStimulus(10, 1'b0, 0, 32'h0, 16'h0000, 32'h0, 4'hF, 6'h07);
    applyStimulus(3, 1'b0, 0, 32'h0, 16'h0008, 32'h0, 4'hF, 6'h09);

    $display("[TB] hung device");
    hungDevice(1);

    $display("[TB] abort with same-clock ack");
    startRequest(4, 1'b0, 16'h0020, 32'h0, 4'hF, 6'h33);
    tick();
    tick();
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    d_ack = oneHot(4);
    d_dat[32*4 +: 32] = 32'h5A5A1234;
    tick();
    d_ack = '0;
    checkOutput("abort_ack", {bus.ack, bus.rdat}, {1'b1, 32'h5A5A1234});
    pulses = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ack) pulses++;
    end
    checkOutput("abort_pulses", pulses, 1);

    $display("[TB] async reset");
    startRequest(6, 1'b0, 16'h0004, 32'h0, 4'hF, 6'h01);
    tick();
    checkOutput("rst_cs_pre", cs, oneHot(6));
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_wait", {cs, bus.ack, bus.rdat}, '0);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    startRequest(7, 1'b0, 16'h0000, 32'h0, 4'hF, 6'h02);
    tick();
    d_ack = oneHot(7);
    d_dat[32*7 +: 32] = 32'h87654321;
    tick();
    d_ack = '0;
    checkOutput("rst_resp_pre", {bus.ack, bus.rdat}, {1'b1, 32'h87654321});
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_resp", {bus.ack, bus.err, bus.rdat}, '0);
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    #3 rst_n = 1'b1;
    tick();

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      applyStimulus($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 4), $urandom,
                    16'($urandom), $urandom, 4'($urandom), 6'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
